fifo_puerto: RTL and testbench

//  Synchronous FIFO that responds to the arbiter's push/pop strobes; it is the storage end of the push/pop handshake.
//  One instance sits on each of the 4 transmit lanes (popped by the arbiter) and each of the 4 receive lanes (pushed by the arbiter).

---
 rtl/fifo_puerto_if.sv | 41 ++++
 rtl/fifo_puerto.sv | 120 ++++++++++++
 tb/tb_fifo_puerto.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_puerto_if.sv
// ----------------------------------------------------------------------------
// fifo_puerto_if
//   Push/pop handshake bundle between the lane arbiter and one fifo_puerto.
//   master : arbiter side, drives push/data_in/pop, observes data and status.
//   slave  : FIFO side, receives strobes, drives data_out and status.
// Signals
//   push, data_in[DATA_WIDTH]  write strobe and write word
//   pop                        read strobe for the head word
//   data_out[DATA_WIDTH], valid  registered read word, valid one cycle after pop
//   empty, almost_empty, full, almost_full, count[ADDR_WIDTH+1]  occupancy status
//   overflow, underflow        sticky error flags
// ----------------------------------------------------------------------------
interface fifo_puerto_if #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH = 2
);
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  empty;
  logic                  almost_empty;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, data_in, pop,
    input  data_out, valid, empty, almost_empty, full, almost_full,
           count, overflow, underflow
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, valid, empty, almost_empty, full, almost_full,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_puerto.sv
// ----------------------------------------------------------------------------
// fifo_puerto
//   Synchronous FIFO at the storage end of the arbiter push/pop handshake.
//   Registered read data (one cycle after pop), status decoded from the
//   registered occupancy count, sticky overflow/underflow flags.
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    fifo_puerto_if.slave (push/data_in/pop in; data_out/valid/status out)
// ----------------------------------------------------------------------------
module fifo_puerto #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned AF_LEVEL   = 3,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic          clk,
  input  logic          reset,
  fifo_puerto_if.slave  bus
);

  localparam int unsigned         DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic empty, full;
  logic wr_ok, rd_ok;

  // Status is a pure decode of the registered count, never of the strobes.
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  // A pop against a full FIFO frees the slot the simultaneous push needs.
  // A push into an empty FIFO is not readable in the same cycle.
  assign wr_ok = bus.push & (~full | bus.pop);
  assign rd_ok = bus.pop & ~empty;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end

    if (rd_ok) begin
      rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
      data_out_d = mem_q[rd_ptr_q];
      valid_d    = 1'b1;
    end

    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (bus.push & full & ~bus.pop) overflow_d  = 1'b1;
    if (bus.pop & empty)            underflow_d = 1'b1;
  end

  // NOTE: storage has no reset; occupancy is tracked by the pointers and count,
  // so stale words are never observable and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.valid        = valid_q;
  assign bus.count        = count_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = ~empty & (count_q <= AE_C);
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_puerto.sv
// ----------------------------------------------------------------------------
// tb_fifo_puerto
//   Directed bench for fifo_puerto (DATA_WIDTH=6, depth 4, AF=3, AE=1):
//   reset, fill, drain, full and empty boundaries, pointer wrap, async reset.
// ----------------------------------------------------------------------------
module tb_fifo_puerto;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  fifo_puerto_if #(.DATA_WIDTH(6), .ADDR_WIDTH(2)) bus ();

  fifo_puerto #(
    .DATA_WIDTH (6),
    .ADDR_WIDTH (2),
    .AF_LEVEL   (3),
    .AE_LEVEL   (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive strobes, take one rising edge, return 1 time unit after it.
  task automatic step(input logic p, input logic [5:0] d, input logic q);
    bus.push    = p;
    bus.data_in = d;
    bus.pop     = q;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 6'h00, 1'b0);
  endtask

  task automatic do_reset();
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"},  32'(bus.count),        32'd0);
    check({tag, "_empty"},  32'(bus.empty),        32'd1);
    check({tag, "_aempty"}, 32'(bus.almost_empty), 32'd0);
    check({tag, "_full"},   32'(bus.full),         32'd0);
    check({tag, "_afull"},  32'(bus.almost_full),  32'd0);
    check({tag, "_valid"},  32'(bus.valid),        32'd0);
    check({tag, "_dout"},   32'(bus.data_out),     32'd0);
    check({tag, "_ovf"},    32'(bus.overflow),     32'd0);
    check({tag, "_udf"},    32'(bus.underflow),    32'd0);
  endtask

  logic [5:0] fill_data [4];
  logic [5:0] exp_data;

  initial begin
    fill_data[0] = 6'h11; fill_data[1] = 6'h22;
    fill_data[2] = 6'h33; fill_data[3] = 6'h24;

    reset       = 1'b1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    reset = 1'b0;

    // Fill: count 1..4, almost_full from 3, full at 4.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, fill_data[i], 1'b0);
      check($sformatf("fill%0d_count", i), 32'(bus.count), 32'(i + 1));
      check($sformatf("fill%0d_empty", i), 32'(bus.empty), 32'd0);
      check($sformatf("fill%0d_aempty", i), 32'(bus.almost_empty), (i == 0) ? 32'd1 : 32'd0);
      check($sformatf("fill%0d_afull", i), 32'(bus.almost_full), (i >= 2) ? 32'd1 : 32'd0);
      check($sformatf("fill%0d_full", i), 32'(bus.full), (i == 3) ? 32'd1 : 32'd0);
    end

    // Drain: words in order, valid one cycle after each pop.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 6'h00, 1'b1);
      check($sformatf("drain%0d_dout", i), 32'(bus.data_out), 32'(fill_data[i]));
      check($sformatf("drain%0d_valid", i), 32'(bus.valid), 32'd1);
      check($sformatf("drain%0d_count", i), 32'(bus.count), 32'(3 - i));
      check($sformatf("drain%0d_aempty", i), 32'(bus.almost_empty), (i == 2) ? 32'd1 : 32'd0);
      check($sformatf("drain%0d_empty", i), 32'(bus.empty), (i == 3) ? 32'd1 : 32'd0);
    end
    idle();
    check("drain_idle_valid", 32'(bus.valid), 32'd0);
    check("drain_idle_hold",  32'(bus.data_out), 32'h24);
    check("drain_no_udf",     32'(bus.underflow), 32'd0);

    // Full boundary: refill, refused push, then push+pop while full.
    for (int i = 0; i < 4; i++) step(1'b1, 6'(6'h31 + i), 1'b0);
    check("refill_full", 32'(bus.full), 32'd1);
    step(1'b1, 6'h3F, 1'b0);
    check("ovf_flag",  32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count), 32'd4);
    check("ovf_valid", 32'(bus.valid), 32'd0);
    step(1'b1, 6'h05, 1'b1);
    check("fullpp_count", 32'(bus.count), 32'd4);
    check("fullpp_dout",  32'(bus.data_out), 32'h31);
    check("fullpp_valid", 32'(bus.valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 6'h00, 1'b1);
      exp_data = (i == 3) ? 6'h05 : 6'(6'h32 + i);
      check($sformatf("fulldrain%0d_dout", i), 32'(bus.data_out), 32'(exp_data));
    end
    check("fulldrain_empty",  32'(bus.empty), 32'd1);
    check("ovf_sticky",       32'(bus.overflow), 32'd1);
    check("fulldrain_no_udf", 32'(bus.underflow), 32'd0);

    // Empty boundary: push+pop while empty, no fall-through.
    do_reset();
    check_reset_state("rst2");
    step(1'b1, 6'h0A, 1'b1);
    check("emptypp_count", 32'(bus.count), 32'd1);
    check("emptypp_udf",   32'(bus.underflow), 32'd1);
    check("emptypp_valid", 32'(bus.valid), 32'd0);
    step(1'b0, 6'h00, 1'b1);
    check("emptypp_dout",  32'(bus.data_out), 32'h0A);
    check("emptypp_valid2", 32'(bus.valid), 32'd1);
    check("emptypp_count2", 32'(bus.count), 32'd0);

    // Wrap: prefill two, then ten push+pop cycles at count 2.
    do_reset();
    step(1'b1, 6'h20, 1'b0);
    step(1'b1, 6'h21, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 6'(i), 1'b1);
      exp_data = (i == 0) ? 6'h20 : (i == 1) ? 6'h21 : 6'(i - 2);
      check($sformatf("wrap%0d_dout", i), 32'(bus.data_out), 32'(exp_data));
      check($sformatf("wrap%0d_valid", i), 32'(bus.valid), 32'd1);
      check($sformatf("wrap%0d_count", i), 32'(bus.count), 32'd2);
    end
    check("wrap_ovf", 32'(bus.overflow), 32'd0);
    check("wrap_udf", 32'(bus.underflow), 32'd0);

    // Async reset: count 3 with valid high and a pop pending.
    step(1'b1, 6'h15, 1'b0);
    step(1'b1, 6'h16, 1'b0);
    step(1'b0, 6'h00, 1'b1);
    check("pre_arst_count", 32'(bus.count), 32'd3);
    check("pre_arst_valid", 32'(bus.valid), 32'd1);
    bus.pop = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("arst");
    @(posedge clk);
    #1;
    check("arst_held_count", 32'(bus.count), 32'd0);
    check("arst_held_udf",   32'(bus.underflow), 32'd0);
    reset = 1'b0;
    step(1'b0, 6'h00, 1'b1);
    check("post_arst_udf",   32'(bus.underflow), 32'd1);
    check("post_arst_valid", 32'(bus.valid), 32'd0);
    check("post_arst_count", 32'(bus.count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
